// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset PC default, NOP encoding
// and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    // REQ: may issue; WAIT: one request outstanding, response wanted;
    // DROP: one request outstanding, response must be thrown away.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrived while decode
// could not take it. Clear wins over load.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pcplus4_i,
    output logic              full_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pcplus4_o
);

    logic              full_q, full_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;

    // Next-state of the entry: clear, load or hold.
    always_comb begin
        full_d    = full_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d    = 1'b1;
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= 1'b0;
            instr_q   <= NOP;
            pcplus4_q <= '0;
        end else begin
            full_q    <= full_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign full_o    = full_q;
    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register. Owns PCF, keeps at most one
// request outstanding to a variable-latency instruction memory, and feeds
// decode through a one-entry skid buffer when decode is stalled.
//
// imem handshake: imem_req is a one-cycle strobe that the memory always
// accepts in the cycle it is high (no ready); exactly one imem_valid strobe
// answers each accepted request, at least one cycle later.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              redirectD,
    input  logic [ADDR_W-1:0] PCRedirectD,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       InstrD,
    output logic [ADDR_W-1:0] PCPlus4D,
    output logic              ValidD,
    output fetch_state_t      dbg_state_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pcf_q, pcf_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q, valid_d;

    logic              req_issue;
    logic              resp_wait;
    logic              capture;
    logic [ADDR_W-1:0] pcf_plus4;
    logic [ADDR_W-1:0] redirect_pc;

    logic              skid_full;
    logic              skid_load;
    logic              skid_clear;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pcplus4;

    assign pcf_plus4   = pcf_q + ADDR_W'(4);
    assign redirect_pc = PCRedirectD & ~ADDR_W'(3);

    // Fetch FSM next state and request strobe; a redirect blocks issue and
    // turns an outstanding response into one to be discarded.
    always_comb begin
        state_d   = state_q;
        req_issue = 1'b0;
        resp_wait = 1'b0;
        case (state_q)
            S_REQ: begin
                req_issue = !StallF && !skid_full && !redirectD;
                if (req_issue) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    resp_wait = 1'b1;
                    state_d   = S_REQ;
                end else if (redirectD) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // A response is kept only if no redirect happens in the same cycle.
    assign capture = resp_wait && !redirectD;

    // Words go straight to IF/ID when it loads and nothing older waits in
    // the skid; otherwise they park in the skid.
    assign skid_load  = capture && (StallD || skid_full);
    assign skid_clear = redirectD || (!StallD && skid_full);

    // PC update: redirect target wins, otherwise advance on a kept word.
    always_comb begin
        pcf_d = pcf_q;
        if (redirectD)    pcf_d = redirect_pc;
        else if (capture) pcf_d = pcf_plus4;
    end

    // IF/ID next state in priority order: stall, flush, skid, response, bubble.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (StallD) begin
            valid_d = valid_q;
        end else if (redirectD) begin
            valid_d = 1'b0;
        end else if (skid_full) begin
            valid_d   = 1'b1;
            instr_d   = skid_instr;
            pcplus4_d = skid_pcplus4;
        end else if (capture) begin
            valid_d   = 1'b1;
            instr_d   = imem_rdata;
            pcplus4_d = pcf_plus4;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, PCF and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pcf_q     <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= NOP;
            pcplus4_q <= '0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (skid_load),
        .clear_i   (skid_clear),
        .instr_i   (imem_rdata),
        .pcplus4_i (pcf_plus4),
        .full_o    (skid_full),
        .instr_o   (skid_instr),
        .pcplus4_o (skid_pcplus4)
    );

    assign imem_req    = req_issue;
    assign imem_addr   = pcf_q;
    assign InstrD      = instr_q;
    assign PCPlus4D    = pcplus4_q;
    assign ValidD      = valid_q;
    assign dbg_state_o = state_q;

endmodule
